// File: rtl/mux_n_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : mux_n_pipe_if
// Description : Valid/ready bus bundle for mux_n_pipe (inputs, output, error).
// Revision    : 1.0 - initial release
// ============================================================================
interface mux_n_pipe_if #(
  parameter int WIDTH = 32,
  parameter int N     = 3,
  parameter int SELW  = 2
) ();
  logic [WIDTH*N-1:0] in_data;
  logic [SELW-1:0]    sel;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   out_data;
  logic               out_valid;
  logic               out_ready;
  logic               sel_err;
  logic               err_clr;

  modport master (
    output in_data, sel, in_valid, out_ready, err_clr,
    input  in_ready, out_data, out_valid, sel_err
  );

  modport slave (
    input  in_data, sel, in_valid, out_ready, err_clr,
    output in_ready, out_data, out_valid, sel_err
  );
endinterface
`default_nettype wire

// File: rtl/mux_n_pipe.sv
`default_nettype none
// ============================================================================
// Module      : mux_n_pipe
// Description : N-way select feeding a STAGES-deep elastic valid/ready pipe.
//               Macro MUX_N_PIPE_OOR_TRAP_EN drops out-of-range selects;
//               otherwise they pass input N-1. Both flag sticky sel_err.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_n_pipe #(
  parameter int WIDTH  = 32,
  parameter int N      = 3,
  parameter int SELW   = 2,
  parameter int STAGES = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  mux_n_pipe_if.slave  bus
);
  localparam int c_last = STAGES - 1;

  if ((N < 2) || (N > 16) || ((2 ** SELW) < N) || (STAGES < 1) || (STAGES > 4))
  begin : g_bad_params
    $error("mux_n_pipe: illegal parameter combination");
  end

  logic [STAGES-1:0] r_vld;
  logic [WIDTH-1:0]  r_data     [STAGES];
  logic              r_sel_err;

  logic              w_sel_oor;
  logic [WIDTH-1:0]  w_sel_data;
  logic              w_in_beat;
  logic              w_accept;
  logic              w_room;
  logic [STAGES-1:0] w_load;
  logic [STAGES-1:0] w_nxt_vld;
  logic [WIDTH-1:0]  w_nxt_data [STAGES];

  // Default to input N-1 so an out-of-range select falls through to it.
  always_comb begin
    w_sel_oor  = (int'(bus.sel) >= N);
    w_sel_data = bus.in_data[(N-1)*WIDTH +: WIDTH];
    for (int i = 0; i < N - 1; i++) begin
      if (int'(bus.sel) == i) w_sel_data = bus.in_data[i*WIDTH +: WIDTH];
    end
  end

`ifdef MUX_N_PIPE_OOR_TRAP_EN
  assign w_in_beat = bus.in_valid && !w_sel_oor;
`else
  assign w_in_beat = bus.in_valid;
`endif

  // A stage may load iff it or any later stage has a free slot, or the
  // consumer is draining the head; the chain is unrolled to avoid a loop.
  always_comb begin
    w_room = bus.out_ready;
    w_load = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      w_room    = w_room | ~r_vld[k];
      w_load[k] = w_room;
    end
  end

  always_comb begin
    w_nxt_vld[0]  = w_in_beat;
    w_nxt_data[0] = w_sel_data;
    for (int k = 1; k < STAGES; k++) begin
      w_nxt_vld[k]  = r_vld[k-1];
      w_nxt_data[k] = r_data[k-1];
    end
  end

  assign w_accept = bus.in_valid && w_load[0];

  // Data only moves with a valid beat, so idle output keeps its last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld     <= '0;
      r_sel_err <= 1'b0;
      for (int k = 0; k < STAGES; k++) r_data[k] <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (w_load[k]) begin
          r_vld[k] <= w_nxt_vld[k];
          if (w_nxt_vld[k]) r_data[k] <= w_nxt_data[k];
        end
      end
      if (w_accept && w_sel_oor) r_sel_err <= 1'b1;
      else if (bus.err_clr)      r_sel_err <= 1'b0;
    end
  end

  assign bus.in_ready  = w_load[0];
  assign bus.out_valid = r_vld[c_last];
  assign bus.out_data  = r_data[c_last];
  assign bus.sel_err   = r_sel_err;
endmodule
`default_nettype wire
